// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Request/result and external 4-bit adder signals of the nibble-serial add/sub controller.
interface nibble_serial_addsub_ctrl_if;
  logic        start;
  logic        sub;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry;
  logic        overflow;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_s;
  logic [3:0]  add_r;
  logic        add_cout;

  modport slave (
    input  start, sub, op_a, op_b, add_r, add_cout,
    output busy, done, result, carry, overflow, add_a, add_b, add_s
  );

  modport master (
    output start, sub, op_a, op_b, add_r, add_cout,
    input  busy, done, result, carry, overflow, add_a, add_b, add_s
  );
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// 16-bit add/subtract computed one nibble per cycle on an external carry-less 4-bit adder;
// inter-nibble carries are folded in by a separate +1 FIX pass.
module nibble_serial_addsub_ctrl (
  input logic                      clk,
  input logic                      rst_n,
  nibble_serial_addsub_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_r, state_s;
  logic [1:0]  idx_r, idx_s;
  logic        cin_r, cin_s;
  logic        c1_r, c1_s;
  logic [15:0] a_r, a_s;
  logic [15:0] b_r, b_s;
  logic        sub_r, sub_s;
  logic [15:0] result_r, result_s;
  logic        carry_r, carry_s;
  logic        overflow_r, overflow_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic [3:0]  add_a_r, add_a_s;
  logic [3:0]  add_b_r, add_b_s;
  logic        add_s_r, add_s_s;

  function automatic logic [3:0] nib(input logic [15:0] v, input logic [1:0] i);
    nib = v[{i, 2'b00} +: 4];
  endfunction

  // Next-state, datapath update and registered adder drive derived from the next state.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    cin_s      = cin_r;
    c1_s       = c1_r;
    a_s        = a_r;
    b_s        = b_r;
    sub_s      = sub_r;
    result_s   = result_r;
    carry_s    = carry_r;
    overflow_s = overflow_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          a_s     = bus.op_a;
          b_s     = bus.op_b;
          sub_s   = bus.sub;
          idx_s   = 2'd0;
          cin_s   = 1'b0;
          state_s = S_ADD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ADD: begin
        result_s[{idx_r, 2'b00} +: 4] = bus.add_r;
        if ((idx_r != 2'd0) && cin_r) begin
          c1_s    = bus.add_cout;
          state_s = S_FIX;
        end else begin
          cin_s = bus.add_cout;
          if (idx_r == 2'd3) begin
            state_s = S_DONE;
          end else begin
            idx_s = idx_r + 2'd1;
          end
        end
      end
      S_FIX: begin
        result_s[{idx_r, 2'b00} +: 4] = bus.add_r;
        cin_s = c1_r | bus.add_cout;
        if (idx_r == 2'd3) begin
          state_s = S_DONE;
        end else begin
          idx_s   = idx_r + 2'd1;
          state_s = S_ADD;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase

    if (state_s == S_DONE) begin
      carry_s    = cin_s;
      overflow_s = (a_s[15] == (b_s[15] ^ sub_s)) && (result_s[15] != a_s[15]);
    end else begin
      carry_s    = carry_r;
      overflow_s = overflow_r;
    end

    // Drive values belong to the cycle after this edge, so they follow the next state.
    case (state_s)
      S_ADD: begin
        add_a_s = nib(a_s, idx_s);
        add_b_s = (sub_s && (idx_s != 2'd0)) ? ~nib(b_s, idx_s) : nib(b_s, idx_s);
        add_s_s = sub_s && (idx_s == 2'd0);
      end
      S_FIX: begin
        add_a_s = nib(result_s, idx_s);
        add_b_s = 4'b0001;
        add_s_s = 1'b0;
      end
      default: begin
        add_a_s = 4'd0;
        add_b_s = 4'd0;
        add_s_s = 1'b0;
      end
    endcase
    busy_s = (state_s == S_ADD) || (state_s == S_FIX);
    done_s = (state_s == S_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      idx_r      <= 2'd0;
      cin_r      <= 1'b0;
      c1_r       <= 1'b0;
      a_r        <= 16'd0;
      b_r        <= 16'd0;
      sub_r      <= 1'b0;
      result_r   <= 16'd0;
      carry_r    <= 1'b0;
      overflow_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      add_a_r    <= 4'd0;
      add_b_r    <= 4'd0;
      add_s_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      cin_r      <= cin_s;
      c1_r       <= c1_s;
      a_r        <= a_s;
      b_r        <= b_s;
      sub_r      <= sub_s;
      result_r   <= result_s;
      carry_r    <= carry_s;
      overflow_r <= overflow_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      add_a_r    <= add_a_s;
      add_b_r    <= add_b_s;
      add_s_r    <= add_s_s;
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.result   = result_r;
  assign bus.carry    = carry_r;
  assign bus.overflow = overflow_r;
  assign bus.add_a    = add_a_r;
  assign bus.add_b    = add_b_r;
  assign bus.add_s    = add_s_r;

endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Bench for nibble_serial_addsub_ctrl: behavioural adder, arithmetic reference model,
// directed corner cases followed by randomized operations.
module tb_nibble_serial_addsub_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  nibble_serial_addsub_ctrl_if bus ();

  nibble_serial_addsub_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External combinational 4-bit adder/subtractor.
  logic [4:0] adder_sum;
  assign adder_sum    = {1'b0, bus.add_a} + {1'b0, (bus.add_s ? ~bus.add_b : bus.add_b)} + {4'd0, bus.add_s};
  assign bus.add_r    = adder_sum[3:0];
  assign bus.add_cout = adder_sum[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".done"}, 32'(bus.done), 32'd0);
    chk({tag, ".result"}, 32'(bus.result), 32'd0);
    chk({tag, ".carry"}, 32'(bus.carry), 32'd0);
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'd0);
    chk({tag, ".add_drive"}, 32'({bus.add_a, bus.add_b, bus.add_s}), 32'd0);
  endtask

  // Reference: full-width arithmetic gives result/flags; nibble carries give the FIX schedule.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input bit noise, input int exp_f);
    logic [15:0] beff;
    logic [16:0] full;
    logic [15:0] er;
    logic        ec;
    logic        eo;
    logic [8:0]  q[$];
    int unsigned am;
    int unsigned bm;
    int unsigned m;
    int          nfix;
    logic [3:0]  an;
    logic [3:0]  bn;
    logic [3:0]  bd;
    beff = s ? ~b : b;
    full = {1'b0, a} + {1'b0, beff} + {16'd0, s};
    er   = full[15:0];
    ec   = full[16];
    eo   = (a[15] == beff[15]) && (er[15] != a[15]);
    nfix = 0;
    for (int i = 0; i < 4; i++) begin
      an = a[4*i +: 4];
      bn = b[4*i +: 4];
      bd = (s && i > 0) ? ~bn : bn;
      q.push_back({an, bd, (s && i == 0)});
      m  = 32'd1 << (4 * i);
      am = 32'(a) % m;
      bm = 32'(beff) % m;
      if (i > 0 && (am + bm + 32'(s)) >= m) begin
        q.push_back({4'(an + bd), 4'b0001, 1'b0});
        nfix++;
      end
    end
    if (exp_f >= 0) chk({tag, ".fix_count_model"}, 32'(q.size()), 32'(4 + exp_f));

    @(negedge clk);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.sub   = s;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    foreach (q[k]) begin
      chk($sformatf("%s.c%0d.busy", tag, k), 32'(bus.busy), 32'd1);
      chk($sformatf("%s.c%0d.done", tag, k), 32'(bus.done), 32'd0);
      chk($sformatf("%s.c%0d.drive", tag, k), 32'({bus.add_a, bus.add_b, bus.add_s}), 32'(q[k]));
      if (noise) begin
        bus.start = 1'b1;
        bus.op_a  = 16'($urandom);
        bus.op_b  = 16'($urandom);
        bus.sub   = 1'($urandom);
      end
      @(posedge clk);
      #1;
    end
    chk({tag, ".done"}, 32'(bus.done), 32'd1);
    chk({tag, ".done_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".result"}, 32'(bus.result), 32'(er));
    chk({tag, ".carry"}, 32'(bus.carry), 32'(ec));
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(eo));
    chk({tag, ".done_drive"}, 32'({bus.add_a, bus.add_b, bus.add_s}), 32'd0);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, ".idle_done"}, 32'(bus.done), 32'd0);
    chk({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".hold_result"}, 32'(bus.result), 32'(er));
    chk({tag, ".hold_flags"}, 32'({bus.carry, bus.overflow}), 32'({ec, eo}));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.op_a  = 16'd0;
    bus.op_b  = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("idle");

    run_op("add_nofix", 16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    run_op("add_fix2",  16'h0001, 16'h00FF, 1'b0, 1'b0, 2);
    run_op("add_fix3",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 3);
    run_op("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b0, -1);
    run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 3);
    run_op("noise",     16'h0001, 16'h00FF, 1'b0, 1'b1, 2);
    run_op("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b1, -1);

    // Reset while in the first FIX pass of 0x0001+0x00FF.
    @(negedge clk);
    bus.op_a  = 16'h0001;
    bus.op_b  = 16'h00FF;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mid.fix_drive", 32'({bus.add_a, bus.add_b, bus.add_s}), 32'({4'hF, 4'b0001, 1'b0}));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("rst_mid");
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst_mid.no_done%0d", c), 32'({bus.done, bus.busy}), 32'd0);
    end
    run_op("after_rst", 16'h0002, 16'h0003, 1'b0, 1'b0, 0);

    for (int r = 0; r < 25; r++) begin
      run_op($sformatf("rand%0d", r), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nibble_serial_addsub_ctrl.md
NIBBLE_SERIAL_ADDSUB_CTRL -- requirements
Module: nibble_serial_addsub_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
REQ-002 The block SHALL provide these request and result ports:
- start  in  1  request strobe, sampled only in IDLE
- sub  in  1  0 = op_a+op_b, 1 = op_a-op_b
- op_a  in  16  first operand
- op_b  in  16  second operand
- busy  out  1  high in ADD and FIX
- done  out  1  one-cycle completion pulse
- result  out  16  sum or difference
- carry  out  1  final carry; for sub, 1 = no borrow
- overflow  out  1  two's-complement signed overflow
REQ-003 The block SHALL drive one external combinational 4-bit adder/subtractor through these ports:
- add_a  out  4  adder first argument
- add_b  out  4  adder second argument
- add_s  out  1  adder mode; 1 inverts add_b and forces carry-in to 1
- add_r  in  4  adder result, valid in the same cycle
- add_cout  in  1  adder carry out
REQ-004 The adder has no free carry-in; nibble carries SHALL be applied by the FIX pass.

Function
REQ-005 States SHALL be IDLE, ADD, FIX and DONE, with a 2-bit nibble index idx, a carry register cin_r and a pass-1 carry register c1_r.
REQ-006 In IDLE, when start=1:
- op_a, op_b and sub are latched.
- idx=0, cin_r=0.
- Next state is ADD.
- Otherwise the block stays in IDLE.
REQ-007 ADD SHALL drive:
- add_a = A[idx]
- add_b = B[idx] if sub=0 or idx=0, else ~B[idx]
- add_s = sub AND (idx==0)
REQ-008 On each ADD edge:
- result[idx] <- add_r.
- If idx>0 and cin_r=1: c1_r <- add_cout, next state FIX.
- Otherwise: cin_r <- add_cout, then go to DONE if idx=3, else idx+1 and stay in ADD.
REQ-009 FIX SHALL drive add_a = result[idx], add_b = 4'b0001, add_s = 0.
REQ-010 On the FIX edge:
- result[idx] <- add_r.
- cin_r <- c1_r OR add_cout.
- Then go to DONE if idx=3, else idx+1 and back to ADD.
REQ-011 FIX SHALL never be entered for idx=0.
REQ-012 DONE SHALL, for one cycle:
- assert done=1 and busy=0
- carry = cin_r
- overflow = (A[15]==Beff[15]) AND (result[15]!=A[15]), where Beff[15] = B[15] XOR sub
- then go to IDLE
REQ-013 Latency: with start sampled at edge e0 and F = number of FIX passes (0..3), done SHALL be high in the cycle after edge e0+4+F.
REQ-014 result, carry and overflow SHALL hold their values from DONE until the next accepted start.
REQ-015 start SHALL be ignored in ADD, FIX and DONE; latched operands SHALL NOT change mid-operation.
REQ-016 In IDLE and DONE, add_a, add_b and add_s SHALL all be 0.

Reset
REQ-017 While rst_n=0 at a rising edge, the block SHALL enter IDLE with every register and output cleared: busy, done, result, carry, overflow, idx, cin_r, c1_r, add_a, add_b, add_s.
REQ-018 A reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst_n=1 SHALL be accepted normally.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- 0x1234+0x4321 -> result 0x5555, carry 0, overflow 0, F=0, done at e0+4.
- 0x0001+0x00FF -> result 0x0100, carry 0, F=2, done at e0+6; check add_b=0001 during both FIX cycles.
- 0xFFFF+0x0001 -> result 0x0000, carry 1, overflow 0, F=3, done at e0+7.
- sub: 0x0005-0x0007 -> result 0xFFFE, carry 0, overflow 0; add_s=1 only during idx 0; add_b=~B nibble for idx>0.
- 0x7FFF+0x0001 -> result 0x8000, overflow 1, carry 0, F=3.
- Start pulses while busy change nothing.
- rst_n=0 during FIX -> next cycle IDLE, all outputs 0, no done pulse.
- Then 0x0002+0x0003 -> result 0x0005.
